// File: rtl/can_bit_sampler.sv
// CAN bit recovery: pin sync, hard/soft bit timing sync,
// stuff-bit removal and stuff-error detection.
module can_bit_sampler #(
  parameter int BIT_CLKS     = 16,
  parameter int SAMPLE_POINT = 11,
  parameter int SJW          = 2,
  parameter int IDLE_BITS    = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic stuff_en,
  output logic bit_valid,
  output logic bit_out,
  output logic sof,
  output logic stuff_err,
  output logic bus_idle,
  output logic frame_active
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam int IW = $clog2(IDLE_BITS + 1);

  typedef logic [CW:0] cx_t;

  localparam cx_t BC = cx_t'(BIT_CLKS);
  localparam cx_t SP = cx_t'(SAMPLE_POINT);
  localparam cx_t SJ = cx_t'(SJW);

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_n;

  logic rx_m, rx_s, rx_d;

  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    run, run_n;
  logic          run_val, run_val_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic          last_bit, last_n;
  logic          smp_done, smp_n;
  logic          sync_done, sync_n;
  logic          first, first_n;

  logic bv_n, bo_n, sof_n, err_n, bi_n, fa_n;

  logic fall, hard, sample, late, early, new_bit;
  logic is_last, is_stuff;
  cx_t  c, c_inc, adj, sum;

  // Sync flops idle recessive so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_comb begin
    fall    = rx_d & ~rx_s;
    hard    = (state == IDLE) && fall;
    c       = hard ? '0 : {1'b0, cnt};
    c_inc   = c + cx_t'(1);
    sample  = (c == SP) && !smp_done;
    late    = 1'b0;
    early   = 1'b0;
    if (state == ACTIVE && fall && last_bit &&
        !sync_done && c != '0) begin
      late  = (c <= SP);
      early = (c > SP);
    end
    new_bit = hard;
    adj     = '0;
    sum     = '0;
    cnt_n   = c_inc[CW-1:0];
    unique case (1'b1)
      late: begin
        adj   = (c < SJ) ? c : SJ;
        cnt_n = CW'(c_inc - adj);
      end
      early: begin
        adj = ((BC - c) < SJ) ? (BC - c) : SJ;
        sum = c_inc + adj;
        if (sum >= BC) begin
          cnt_n   = CW'(sum - BC);
          new_bit = 1'b1;
        end else begin
          cnt_n = CW'(sum);
        end
      end
      default: begin
        if (c_inc == BC) begin
          cnt_n   = '0;
          new_bit = 1'b1;
        end
      end
    endcase
    // Flags live for one bit period; a bit period ends on wrap
    smp_n  = (smp_done | sample) & ~new_bit;
    sync_n = (sync_done | late | early) & ~new_bit;
    last_n = sample ? rx_s : last_bit;
  end

  always_comb begin
    state_n   = state;
    run_n     = run;
    run_val_n = run_val;
    idle_n    = idle_cnt;
    first_n   = first;
    bv_n      = 1'b0;
    bo_n      = bit_out;
    sof_n     = 1'b0;
    err_n     = 1'b0;
    bi_n      = bus_idle;
    fa_n      = frame_active;
    is_last   = (idle_cnt == IW'(IDLE_BITS - 1));
    is_stuff  = stuff_en && (run == 3'd5);
    unique case (state)
      INTEGRATE: begin
        if (sample) begin
          if (!rx_s) begin
            idle_n = '0;
          end else if (is_last) begin
            idle_n  = '0;
            state_n = IDLE;
            bi_n    = 1'b1;
          end else begin
            idle_n = idle_cnt + IW'(1);
          end
        end
      end
      IDLE: begin
        if (hard) begin
          state_n = ACTIVE;
          fa_n    = 1'b1;
          bi_n    = 1'b0;
          run_n   = '0;
          idle_n  = '0;
          first_n = 1'b1;
        end
      end
      ACTIVE: begin
        if (sample) begin
          if (is_stuff && rx_s == run_val) begin
            err_n   = 1'b1;
            fa_n    = 1'b0;
            state_n = INTEGRATE;
            run_n   = '0;
            idle_n  = '0;
          end else begin
            if (is_stuff) begin
              run_n = 3'd1;
            end else begin
              bv_n    = 1'b1;
              bo_n    = rx_s;
              sof_n   = first;
              first_n = 1'b0;
              if (run != '0 && rx_s == run_val)
                run_n = (run == 3'd5) ? run : run + 3'd1;
              else
                run_n = 3'd1;
            end
            run_val_n = rx_s;
            if (!rx_s) begin
              idle_n = '0;
            end else if (is_last) begin
              idle_n  = '0;
              state_n = IDLE;
              bi_n    = 1'b1;
              fa_n    = 1'b0;
            end else begin
              idle_n = idle_cnt + IW'(1);
            end
          end
        end
      end
      default: state_n = INTEGRATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INTEGRATE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      run          <= '0;
      run_val      <= 1'b0;
      idle_cnt     <= '0;
      last_bit     <= 1'b1;
      smp_done     <= 1'b0;
      sync_done    <= 1'b0;
      first        <= 1'b0;
      bit_valid    <= 1'b0;
      bit_out      <= 1'b0;
      sof          <= 1'b0;
      stuff_err    <= 1'b0;
      bus_idle     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      run          <= run_n;
      run_val      <= run_val_n;
      idle_cnt     <= idle_n;
      last_bit     <= last_n;
      smp_done     <= smp_n;
      sync_done    <= sync_n;
      first        <= first_n;
      bit_valid    <= bv_n;
      bit_out      <= bo_n;
      sof          <= sof_n;
      stuff_err    <= err_n;
      bus_idle     <= bi_n;
      frame_active <= fa_n;
    end
  end

endmodule

// File: tb/tb_can_bit_sampler.sv
// Directed bench for can_bit_sampler: idle integration,
// de-stuffing, stuff error, resync and mid-frame reset.
module tb_can_bit_sampler;

  logic clk = 1'b0;
  logic rst, rx, stuff_en;
  logic bit_valid, bit_out, sof;
  logic stuff_err, bus_idle, frame_active;

  int tests = 0;
  int fails = 0;
  int now   = 0;
  int nv    = 0;
  int nerr  = 0;
  int adj   = 0;
  logic prev_bv = 1'b0;

  // rx se v o e fa: pin level, stuff_en, expected strobe,
  // bit_out, stuff_err and frame_active at sample+1
  typedef struct packed {
    logic rx;
    logic se;
    logic v;
    logic o;
    logic e;
    logic fa;
  } vec_t;

  vec_t tbl[17];

  always #5 clk = ~clk;

  can_bit_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .stuff_en     (stuff_en),
    .bit_valid    (bit_valid),
    .bit_out      (bit_out),
    .sof          (sof),
    .stuff_err    (stuff_err),
    .bus_idle     (bus_idle),
    .frame_active (frame_active)
  );

  always @(negedge clk) begin
    if (bit_valid) nv <= nv + 1;
    if (stuff_err) nerr <= nerr + 1;
    if (bit_valid && prev_bv) adj <= adj + 1;
    prev_bv <= bit_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic at(input int c);
    while (now < c) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, now);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bv"},  bit_valid,    0);
    chk({tag, "_bo"},  bit_out,      0);
    chk({tag, "_sof"}, sof,          0);
    chk({tag, "_err"}, stuff_err,    0);
    chk({tag, "_bi"},  bus_idle,     0);
    chk({tag, "_fa"},  frame_active, 0);
  endtask

  initial begin
    int r, t, t2, r3, n0, n1;
    tbl[0]  = 6'b111101;
    tbl[1]  = 6'b011001;
    tbl[2]  = 6'b111101;
    tbl[3]  = 6'b111101;
    for (int i = 4; i <= 8; i++) tbl[i] = 6'b011001;
    tbl[9]  = 6'b110001;
    for (int i = 10; i <= 14; i++) tbl[i] = 6'b011001;
    tbl[15] = 6'b001001;
    tbl[16] = 6'b010010;

    rst = 1'b1;
    rx = 1'b1;
    stuff_en = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    r = now;

    at(r + 171);
    chk("idle_pre", bus_idle, 0);
    tick();
    chk("idle_rise", bus_idle, 1);
    chk("idle_fa", frame_active, 0);

    t = r + 176;
    at(t);
    rx = 1'b0;
    stuff_en = 1'b1;
    at(t + 13);
    chk("sof_early", bit_valid, 0);
    tick();
    chk("sof_bv", bit_valid, 1);
    chk("sof_sof", sof, 1);
    chk("sof_bo", bit_out, 0);
    chk("sof_fa", frame_active, 1);
    chk("sof_bi", bus_idle, 0);

    for (int k = 1; k <= 17; k++) begin
      at(t + 16 * k);
      rx = tbl[k-1].rx;
      stuff_en = tbl[k-1].se;
      at(t + 13 + 16 * k);
      chk($sformatf("row%0d_gap", k), bit_valid, 0);
      tick();
      chk($sformatf("row%0d_bv", k), bit_valid, int'(tbl[k-1].v));
      chk($sformatf("row%0d_bo", k), bit_out, int'(tbl[k-1].o));
      chk($sformatf("row%0d_err", k), stuff_err, int'(tbl[k-1].e));
      chk($sformatf("row%0d_fa", k), frame_active, int'(tbl[k-1].fa));
      chk($sformatf("row%0d_sof", k), sof, 0);
    end
    n0 = nv;

    at(t + 16 * 18);
    rx = 1'b1;
    at(t + 16 * 28);
    rx = 1'b0;
    at(t + 16 * 29);
    rx = 1'b1;
    at(t + 16 * 39 + 13);
    chk("reint_pre", bus_idle, 0);
    tick();
    chk("reint_idle", bus_idle, 1);
    chk("reint_fa", frame_active, 0);
    chk("reint_nobits", nv, n0);

    t2 = t + 16 * 40 + 3;
    at(t2);
    rx = 1'b0;
    at(t2 + 14);
    chk("f2_sof", sof, 1);
    chk("f2_bv", bit_valid, 1);
    at(t2 + 16);
    rx = 1'b1;
    at(t2 + 30);
    chk("f2_b1_bv", bit_valid, 1);
    chk("f2_b1_bo", bit_out, 1);
    at(t2 + 33);
    rx = 1'b0;
    at(t2 + 46);
    chk("late_early", bit_valid, 0);
    tick();
    chk("late_bv", bit_valid, 1);
    chk("late_bo", bit_out, 0);
    at(t2 + 49);
    rx = 1'b1;
    at(t2 + 63);
    chk("f2_b3_bv", bit_valid, 1);
    chk("f2_b3_bo", bit_out, 1);
    rx = 1'b0;
    at(t2 + 76);
    chk("short_early", bit_valid, 0);
    tick();
    chk("short_bv", bit_valid, 1);
    chk("short_bo", bit_out, 0);
    at(t2 + 79);
    rx = 1'b1;
    at(t2 + 93);
    chk("f2_b5_bv", bit_valid, 1);
    chk("f2_b5_bo", bit_out, 1);
    chk("f2_b5_fa", frame_active, 1);

    at(t2 + 95);
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    r3 = now;
    n1 = nv;
    rx = 1'b0;
    at(r3 + 20);
    rx = 1'b1;
    at(r3 + 187);
    chk("rst_idle_pre", bus_idle, 0);
    tick();
    chk("rst_idle", bus_idle, 1);
    chk("rst_nobits", nv, n1);
    at(r3 + 190);
    rx = 1'b0;
    at(r3 + 203);
    chk("f3_early", bit_valid, 0);
    tick();
    chk("f3_bv", bit_valid, 1);
    chk("f3_sof", sof, 1);
    chk("f3_bo", bit_out, 0);
    tick();
    chk("total_bits", nv, 23);
    chk("total_err", nerr, 1);
    chk("no_adjacent", adj, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/can_bit_sampler.md
# can_bit_sampler

Recovers CAN bits from the raw `rx` pin using a fixed-rate system clock, removes stuff bits, and flags stuff errors. It sits directly upstream of the one-hot bit capture stage. `bit_valid` drives the capture stage's enable and `bit_out` drives its `rx`, so the capture stage sees exactly one strobe per de-stuffed frame bit.

## Interface
Parameters:
- `BIT_CLKS`, default 16: `clk` cycles per nominal bit time; legal range 8..64.
- `SAMPLE_POINT`, default 11: value of the bit-phase counter at which `rx` is sampled; legal range 2..`BIT_CLKS`-2.
- `SJW`, default 2: maximum phase correction per resynchronisation, in clocks; legal range 1..4.
- `IDLE_BITS`, default 11: number of consecutive recessive sampled bits that declares the bus idle.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  raw CAN receive pin; 1 = recessive. Asynchronous to `clk`.
- `stuff_en`  in  1  driven high by the downstream decoder from SOF through the end of the CRC field; low disables de-stuffing.
- `bit_valid`  out  1  single-cycle strobe; one per delivered (non-stuff) bit.
- `bit_out`  out  1  sampled bit value; valid while `bit_valid` is high, held otherwise.
- `sof`  out  1  single-cycle strobe coincident with `bit_valid` of the SOF bit.
- `stuff_err`  out  1  single-cycle strobe on a stuff violation.
- `bus_idle`  out  1  high while the bus is integrated and idle.
- `frame_active`  out  1  high from the SOF sample until a stuff error or `IDLE_BITS` recessive bits.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rx_s`. A falling edge is the cycle where `rx_s`=0 and the previous `rx_s`=1.
- Bit-phase counter `cnt` runs 0..`BIT_CLKS`-1 and wraps to 0. `rx_s` is sampled on the cycle `cnt`==`SAMPLE_POINT`.
- State machine:
  - INTEGRATE, entered on reset: counts consecutive recessive samples. A dominant sample clears the count. At `IDLE_BITS` the block moves to IDLE and sets `bus_idle`=1.
  - IDLE: `cnt` free-runs but produces no outputs. On a falling edge (hard sync) that cycle is `cnt`=0. The block moves to ACTIVE, sets `frame_active`=1, and clears `bus_idle`.
  - ACTIVE: each sample produces a bit subject to the stuff rules.
    - A stuff error clears `frame_active` and returns the block to INTEGRATE.
    - `IDLE_BITS` consecutive recessive samples set `bus_idle`, clear `frame_active`, and return the block to IDLE.
- Resynchronisation applies in ACTIVE only, at most once per bit, and only on a falling edge when the last sampled bit was recessive.
  - Edge at `cnt`=0: no correction.
  - Edge at `cnt` in 1..`SAMPLE_POINT`: the next `cnt` is `cnt`+1-min(`cnt`,`SJW`), which delays the sample.
  - Edge at `cnt` > `SAMPLE_POINT`: `cnt` advances by 1+min(`BIT_CLKS`-`cnt`,`SJW`), wrapping to 0, which shortens the bit.
- Stuff rules:
  - A run counter tracks consecutive equal sampled bits, including SOF and stuff bits. It saturates at 5.
  - When `stuff_en`=1 and run==5, the next sample is a stuff bit.
    - If it is opposite to the run value, it is dropped (no `bit_valid`) and run restarts at 1 with the new value.
    - If it equals the run value, `stuff_err` pulses, no `bit_valid` is issued, and the block enters INTEGRATE.
  - When `stuff_en`=0, no bit is treated as stuff, but the run counter still tracks.
- `rst` held high at any time, including mid-frame, returns the block to INTEGRATE with all outputs 0 and all counters 0.

## Timing
- Reset values: `bit_valid`=`bit_out`=`sof`=`stuff_err`=`bus_idle`=`frame_active`=0; `cnt`=0; run=0; idle count=0.
- Pin-to-sync latency: a pin change at cycle T appears at `rx_s` at T+2.
- Hard-sync edge detect at cycle E gives: sample at E+`SAMPLE_POINT`, and `bit_valid`/`sof` high at E+`SAMPLE_POINT`+1.
- Bits without correction are exactly `BIT_CLKS` cycles apart; `bit_valid` is never high on two adjacent cycles.
- `stuff_err` pulses at sample+1, the same slot `bit_valid` would have occupied. `frame_active` is low from sample+1.
- `bus_idle` and the `frame_active` clear take effect at sample+1 of the `IDLE_BITS`th recessive bit.
- `stuff_en` is sampled on the sample cycle. Changes between samples take effect on the next bit.
- If a falling edge and the sample point coincide, the sample uses `rx_s` of that cycle and then the resync applies.

## Test plan
- Reset, hold `rx`=1 for 11 bit times: `bus_idle` rises 1 cycle after the 11th sample. Then drive `rx`=0 at T: `bit_valid`, `sof`, and `bit_out`=0 all at T+2+11+1 = T+14.
- Frame bits 0,1,0,1,1,0 with `stuff_en`=1: exactly 6 `bit_valid` strobes, 16 cycles apart, with matching `bit_out`.
- SOF plus 0000 then 1 (stuff) then 0: 5 dominant bits delivered, the stuff bit dropped, then `bit_out`=0. Run restarts correctly.
- Six consecutive dominant samples with `stuff_en`=1: `stuff_err` pulses once, `frame_active`=0, no 6th `bit_valid`. Eleven recessive bits are then required before the next SOF is accepted.
- Edge arriving 1 clock late (cnt=1) after a recessive bit: the next sample is delayed by 1 clock. Edge at cnt=14: the bit is shortened by 2 clocks (SJW clamp).
- Assert `rst` for 1 cycle mid-frame: all outputs 0 next cycle. No `bit_valid` until 11 recessive bits followed by a new falling edge.
